in_fifo_drain: RTL and testbench

Read-side drain controller for the PHY-lane input FIFO, clocked entirely in the RDCLK domain. It watches the FIFO's EMPTY/ALMOSTEMPTY flags, issues RDEN pulses, captures the ten 8-bit Q lanes one cycle later and presents them as an 80-bit valid/ready stream to the fabric consumer. A 2-entry output buffer absorbs consumer back-pressure without losing FIFO words. Read, underrun and stall counters support bring-up.

---
 rtl/in_fifo_drain.sv | 168 ++++++++++++++++
 tb/tb_in_fifo_drain.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_fifo_drain.sv
// Read-side drain controller for the PHY-lane input FIFO (RDCLK domain).
// Issues credit-limited RDEN pulses and streams captured lane words out.
module in_fifo_drain #(
    parameter int LANE_W = 8,
    parameter int LANES  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                 RDCLK,
    input  logic                 RESET,
    input  logic                 EMPTY,
    input  logic                 ALMOSTEMPTY,
    input  logic [7:0]           Q0,
    input  logic [7:0]           Q1,
    input  logic [7:0]           Q2,
    input  logic [7:0]           Q3,
    input  logic [7:0]           Q4,
    input  logic [7:0]           Q5,
    input  logic [7:0]           Q6,
    input  logic [7:0]           Q7,
    input  logic [7:0]           Q8,
    input  logic [7:0]           Q9,
    output logic                 RDEN,
    output logic [LANES*8-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 enable,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 underrun,
    output logic [CNT_W-1:0]     stall_count,
    input  logic                 clr_stats
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_SINGLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LANE_MASK = 8'((9'd1 << LANE_W) - 9'd1);

    state_t               r_state;
    logic                 r_rden;
    logic [1:0]           r_occ;
    logic [LANES*8-1:0]   r_buf0;
    logic [LANES*8-1:0]   r_buf1;
    logic [CNT_W-1:0]     r_rd_count;
    logic [CNT_W-1:0]     r_stall_count;
    logic                 r_underrun;

    logic [7:0]           w_q [10];
    logic [LANES*8-1:0]   w_word;
    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_sum;
    logic [1:0]           w_widx;
    logic                 w_credit;
    logic                 w_go;

    assign w_q = '{Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9};

    always_comb begin
        w_word = '0;
        for (int i = 0; i < LANES; i++) begin
            w_word[i*8 +: 8] = w_q[i] & LANE_MASK;
        end
    end

    // The word read by the current RDEN lands at the next edge, so the
    // outstanding read counts against the 2-entry buffer.
    assign w_pop    = m_valid & m_ready;
    assign w_push   = r_rden;
    assign w_sum    = r_occ + {1'b0, r_rden} - {1'b0, w_pop};
    assign w_widx   = r_occ - {1'b0, w_pop};
    assign w_credit = (w_sum < 2'd2);
    assign w_go     = enable & ~EMPTY & w_credit;

    always_ff @(posedge RDCLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_rden  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_rden <= w_go;
                    if (w_go) begin
                        r_state <= ALMOSTEMPTY ? S_SINGLE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (EMPTY || !enable) begin
                        r_state <= S_IDLE;
                        r_rden  <= 1'b0;
                    end else if (!w_credit) begin
                        r_rden  <= 1'b0;
                    end else if (ALMOSTEMPTY) begin
                        r_state <= S_SINGLE;
                        r_rden  <= 1'b1;
                    end else begin
                        r_rden  <= 1'b1;
                    end
                end
                S_SINGLE: begin
                    r_state <= S_WAIT;
                    r_rden  <= 1'b0;
                end
                S_WAIT: begin
                    r_state <= S_IDLE;
                    r_rden  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rden  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge RDCLK or negedge RESET) begin
        if (!RESET) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (w_push) begin
                if (w_widx == 2'd0) begin
                    r_buf0 <= w_word;
                end else begin
                    r_buf1 <= w_word;
                end
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge RDCLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_count    <= '0;
            r_stall_count <= '0;
            r_underrun    <= 1'b0;
        end else if (clr_stats) begin
            r_rd_count    <= '0;
            r_stall_count <= '0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_push && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            if (m_valid && !m_ready && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (r_rden && EMPTY) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign RDEN        = r_rden;
    assign m_data      = r_buf0;
    assign m_valid     = (r_occ != 2'd0);
    assign rd_count    = r_rd_count;
    assign stall_count = r_stall_count;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_in_fifo_drain.sv
// Directed bench for in_fifo_drain: FIFO model, output scoreboard,
// back-pressure, underrun, mid-stream reset and 4-bit lane mode.
module tb_in_fifo_drain;

    logic        RDCLK;
    logic        RESET;
    logic        EMPTY;
    logic        ALMOSTEMPTY;
    logic [7:0]  q [10];
    logic        RDEN;
    logic [79:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        enable;
    logic [15:0] rd_count;
    logic        underrun;
    logic [15:0] stall_count;
    logic        clr_stats;

    logic        rden4;
    logic [79:0] m_data4;
    logic        m_valid4;
    logic        enable4;
    logic [15:0] rd_count4;
    logic        underrun4;
    logic [15:0] stall_count4;
    logic [7:0]  q4;
    logic        lo;
    logic        hi;

    int          f_cnt = 0;
    int          f_rptr = 0;
    logic        ld = 1'b0;
    int          ld_base = 0;
    int          ld_n = 0;
    logic        force_empty = 1'b0;

    logic [79:0] got [$];
    int          rden_total = 0;
    int          rden4_total = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    in_fifo_drain u_dut (
        .RDCLK       (RDCLK),
        .RESET       (RESET),
        .EMPTY       (EMPTY),
        .ALMOSTEMPTY (ALMOSTEMPTY),
        .Q0          (q[0]),
        .Q1          (q[1]),
        .Q2          (q[2]),
        .Q3          (q[3]),
        .Q4          (q[4]),
        .Q5          (q[5]),
        .Q6          (q[6]),
        .Q7          (q[7]),
        .Q8          (q[8]),
        .Q9          (q[9]),
        .RDEN        (RDEN),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .enable      (enable),
        .rd_count    (rd_count),
        .underrun    (underrun),
        .stall_count (stall_count),
        .clr_stats   (clr_stats)
    );

    in_fifo_drain #(.LANE_W(4)) u_dut4 (
        .RDCLK       (RDCLK),
        .RESET       (RESET),
        .EMPTY       (lo),
        .ALMOSTEMPTY (lo),
        .Q0          (q4),
        .Q1          (q4),
        .Q2          (q4),
        .Q3          (q4),
        .Q4          (q4),
        .Q5          (q4),
        .Q6          (q4),
        .Q7          (q4),
        .Q8          (q4),
        .Q9          (q4),
        .RDEN        (rden4),
        .m_data      (m_data4),
        .m_valid     (m_valid4),
        .m_ready     (hi),
        .enable      (enable4),
        .rd_count    (rd_count4),
        .underrun    (underrun4),
        .stall_count (stall_count4),
        .clr_stats   (lo)
    );

    initial RDCLK = 1'b0;
    always #5 RDCLK = ~RDCLK;

    assign lo = 1'b0;
    assign hi = 1'b1;
    assign q4 = 8'hAB;

    // FIFO model: head word on Q, popped at an edge that sees RDEN
    always @(posedge RDCLK) begin
        if (ld) begin
            f_cnt  <= ld_n;
            f_rptr <= ld_base;
        end else if (RDEN && f_cnt > 0) begin
            f_cnt  <= f_cnt - 1;
            f_rptr <= f_rptr + 1;
        end
    end

    assign EMPTY       = (f_cnt == 0) || force_empty;
    assign ALMOSTEMPTY = (f_cnt <= 2);

    always_comb begin
        for (int j = 0; j < 10; j++) begin
            q[j] = 8'(f_rptr + 16 * j);
        end
    end

    always @(negedge RDCLK) begin
        if (m_valid && m_ready) got.push_back(m_data);
        if (RDEN) rden_total++;
        if (rden4) rden4_total++;
    end

    function automatic logic [79:0] exp_word(input int k);
        logic [79:0] w;
        for (int j = 0; j < 10; j++) begin
            w[j*8 +: 8] = 8'(k + 16 * j);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [79:0] act,
                         input logic [79:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic ld_fifo(input int base, input int n);
        ld_base = base;
        ld_n    = n;
        ld      = 1'b1;
        @(posedge RDCLK);
        #1;
        ld      = 1'b0;
    endtask

    task automatic nedge(input int k);
        repeat (k) @(posedge RDCLK);
        @(negedge RDCLK);
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            @(posedge RDCLK);
            #1;
            c++;
        end
        check(tag, 80'(got.size() >= n), 80'd1);
        @(negedge RDCLK);
    endtask

    initial begin
        int g0;
        int r0;
        logic [79:0] exp4;

        RESET     = 1'b0;
        m_ready   = 1'b0;
        enable    = 1'b0;
        clr_stats = 1'b0;
        enable4   = 1'b0;
        nedge(2);
        check("rst_rden", 80'(RDEN), 80'd0);
        check("rst_valid", 80'(m_valid), 80'd0);
        check("rst_data", m_data, 80'd0);
        check("rst_rdcnt", 80'(rd_count), 80'd0);
        check("rst_stall", 80'(stall_count), 80'd0);
        check("rst_undr", 80'(underrun), 80'd0);
        RESET   = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        nedge(1);

        // burst of 8 words, streaming then a final single read
        g0 = got.size();
        r0 = rden_total;
        ld_fifo(0, 8);
        nedge(0);
        check("lat_rden0", 80'(RDEN), 80'd0);
        nedge(1);
        check("lat_rden1", 80'(RDEN), 80'd1);
        check("lat_valid0", 80'(m_valid), 80'd0);
        nedge(1);
        check("lat_valid1", 80'(m_valid), 80'd1);
        check("lat_data", m_data, exp_word(0));
        wait_words("burst_n", g0 + 8, 40);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("burst_w%0d", k), got[g0 + k], exp_word(k));
        end
        check("burst_rdcnt", 80'(rd_count), 80'd8);
        check("burst_undr", 80'(underrun), 80'd0);
        check("burst_rden", 80'(rden_total - r0), 80'd8);

        // back-pressure: buffer fills to 2, then drains losslessly
        m_ready = 1'b0;
        g0 = got.size();
        r0 = rden_total;
        ld_fifo(64, 8);
        nedge(10);
        check("bp_rden", 80'(rden_total - r0), 80'd2);
        check("bp_valid", 80'(m_valid), 80'd1);
        check("bp_rdenlo", 80'(RDEN), 80'd0);
        check("bp_stall", 80'(stall_count), 80'd8);
        @(posedge RDCLK);
        #1;
        m_ready = 1'b1;
        wait_words("bp_n", g0 + 8, 40);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bp_w%0d", k), got[g0 + k], exp_word(64 + k));
        end
        nedge(5);
        check("bp_count", 80'(got.size() - g0), 80'd8);
        check("bp_stall2", 80'(stall_count), 80'd9);
        check("bp_rdcnt", 80'(rd_count), 80'd16);

        clr_stats = 1'b1;
        nedge(1);
        clr_stats = 1'b0;
        check("clr_rdcnt", 80'(rd_count), 80'd0);
        check("clr_stall", 80'(stall_count), 80'd0);

        // one word left with ALMOSTEMPTY: single read, then wait
        r0 = rden_total;
        ld_fifo(128, 1);
        nedge(1);
        check("ae_rden1", 80'(RDEN), 80'd1);
        nedge(1);
        check("ae_rden0", 80'(RDEN), 80'd0);
        check("ae_valid", 80'(m_valid), 80'd1);
        check("ae_data", m_data, exp_word(128));
        nedge(1);
        check("ae_wait", 80'(RDEN), 80'd0);
        nedge(4);
        check("ae_pulses", 80'(rden_total - r0), 80'd1);
        check("ae_rdcnt", 80'(rd_count), 80'd1);
        check("ae_undr", 80'(underrun), 80'd0);

        // EMPTY forced high under an outstanding RDEN
        g0 = got.size();
        ld_fifo(192, 4);
        @(posedge RDCLK);
        #1;
        force_empty = 1'b1;
        nedge(1);
        check("ur_set", 80'(underrun), 80'd1);
        force_empty = 1'b0;
        nedge(20);
        check("ur_sticky", 80'(underrun), 80'd1);
        check("ur_count", 80'(got.size() - g0), 80'd4);
        check("ur_last", got[g0 + 3], exp_word(195));
        check("ur_rdcnt", 80'(rd_count), 80'd5);
        clr_stats = 1'b1;
        nedge(1);
        clr_stats = 1'b0;
        check("ur_clr", 80'(underrun), 80'd0);

        // reset with a full output buffer
        m_ready = 1'b0;
        ld_fifo(32, 8);
        nedge(4);
        check("mr_pre", 80'(m_valid), 80'd1);
        RESET = 1'b0;
        #1;
        check("mr_rden", 80'(RDEN), 80'd0);
        check("mr_valid", 80'(m_valid), 80'd0);
        check("mr_data", m_data, 80'd0);
        check("mr_rdcnt", 80'(rd_count), 80'd0);
        check("mr_stall", 80'(stall_count), 80'd0);
        nedge(1);
        RESET   = 1'b1;
        m_ready = 1'b1;
        g0 = got.size();
        wait_words("mr_n", g0 + 6, 40);
        check("mr_first", got[g0], exp_word(34));
        nedge(5);
        check("mr_count", 80'(got.size() - g0), 80'd6);

        // 4-bit lanes: upper nibble of every lane zeroed
        enable4 = 1'b1;
        nedge(6);
        exp4 = {10{8'h0B}};
        check("l4_valid", 80'(m_valid4), 80'd1);
        check("l4_data", m_data4, exp4);
        check("l4_rd", 80'(rd_count4 != 16'd0), 80'd1);
        enable4 = 1'b0;
        nedge(3);
        r0 = rden4_total;
        nedge(5);
        check("l4_off", 80'(rden4_total - r0), 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
